// File: rtl/shapool_job_loader.sv
// Job front-end for shapool: assembles a 46-byte job stream, sequences the core reset, captures the result.
// One byte per cycle in LOAD, a single ARM stall cycle, then RUN until success, timeout or a new byte (abort).
module shapool_job_loader #(
    parameter int          TIMEOUT_W      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] sha_state,
    output logic [95:0]  message_head,
    output logic [7:0]   difficulty,
    output logic [7:0]   nonce_start_MSB,
    output logic         core_reset,
    input  logic         core_success,
    input  logic [31:0]  core_nonce,
    output logic         result_valid,
    output logic         result_found,
    output logic [31:0]  result_nonce,
    output logic         busy
);

    typedef enum logic [1:0] {S_LOAD, S_ARM, S_RUN, S_DONE} state_t;

    localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] RUN_LIMIT  = TIMEOUT_W'(TIMEOUT_CYCLES - 32'd1);

    state_t               state;
    state_t               state_next;
    logic [5:0]           count;
    logic [TIMEOUT_W-1:0] run_count;
    logic                 accept;
    logic                 timed_out;

    assign accept    = in_valid && in_ready;
    assign timed_out = TIMEOUT_EN && (run_count == RUN_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = (state != S_ARM);
        busy       = (state == S_ARM) || (state == S_RUN);
        case (state)
            S_LOAD: if (accept && count == 6'd45) state_next = S_ARM;
            S_ARM:  state_next = S_RUN;
            S_RUN: begin
                if (accept)                         state_next = S_LOAD;
                else if (core_success || timed_out) state_next = S_DONE;
            end
            S_DONE: if (accept) state_next = S_LOAD;
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count           <= '0;
            run_count       <= '0;
            sha_state       <= '0;
            message_head    <= '0;
            difficulty      <= '0;
            nonce_start_MSB <= '0;
            core_reset      <= 1'b1;
            result_valid    <= 1'b0;
            result_found    <= 1'b0;
            result_nonce    <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        for (int i = 0; i < 32; i++)
                            if (count == 6'(i)) sha_state[8*(31-i) +: 8] <= in_data;
                        for (int i = 0; i < 12; i++)
                            if (count == 6'(32 + i)) message_head[8*(11-i) +: 8] <= in_data;
                        if (count == 6'd44) difficulty      <= in_data;
                        if (count == 6'd45) nonce_start_MSB <= in_data;
                        count <= (count == 6'd45) ? 6'd0 : count + 6'd1;
                    end
                end
                S_ARM: begin
                    run_count  <= '0;
                    core_reset <= 1'b0;
                end
                S_RUN, S_DONE: begin
                    if (state == S_RUN) run_count <= run_count + 1'b1;
                    // A new byte always wins: it restarts the job as byte 0 and drops any result.
                    if (accept) begin
                        sha_state[255:248] <= in_data;
                        count              <= 6'd1;
                        core_reset         <= 1'b1;
                        result_valid       <= 1'b0;
                        result_found       <= 1'b0;
                        result_nonce       <= '0;
                    end else if (state == S_RUN && core_success) begin
                        core_reset   <= 1'b1;
                        result_valid <= 1'b1;
                        result_found <= 1'b1;
                        result_nonce <= core_nonce;
                    end else if (state == S_RUN && timed_out) begin
                        core_reset   <= 1'b1;
                        result_valid <= 1'b1;
                        result_found <= 1'b0;
                        result_nonce <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shapool_job_loader.sv
// Self-checking bench for shapool_job_loader: directed vectors plus random traffic against a byte-array job model.
module tb_shapool_job_loader;

    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] sha_state;
    logic [95:0]  message_head;
    logic [7:0]   difficulty;
    logic [7:0]   nonce_start_MSB;
    logic         core_reset;
    logic         core_success;
    logic [31:0]  core_nonce;
    logic         result_valid;
    logic         result_found;
    logic [31:0]  result_nonce;
    logic         busy;

    int total = 0;
    int bad   = 0;

    shapool_job_loader #(.TIMEOUT_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sha_state(sha_state), .message_head(message_head), .difficulty(difficulty),
        .nonce_start_MSB(nonce_start_MSB), .core_reset(core_reset), .core_success(core_success),
        .core_nonce(core_nonce), .result_valid(result_valid), .result_found(result_found),
        .result_nonce(result_nonce), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: the job is a plain byte array; the phase follows the block's documented life cycle.
    localparam int M_LOAD = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3;
    logic [7:0]  job [46];
    int          m_phase, m_cnt, m_elapsed;
    bit          m_rv, m_rf;
    logic [31:0] m_rn;

    task automatic m_abort();
        job[0] = in_data; m_cnt = 1; m_phase = M_LOAD;
        m_rv = 0; m_rf = 0; m_rn = 0;
    endtask

    task automatic model_step();
        bit acc;
        acc = in_valid && (m_phase != M_ARM);
        if (reset) begin
            foreach (job[i]) job[i] = 8'h00;
            m_phase = M_LOAD; m_cnt = 0; m_elapsed = 0; m_rv = 0; m_rf = 0; m_rn = 0;
        end else begin
            case (m_phase)
                M_LOAD: if (acc) begin
                    job[m_cnt] = in_data;
                    if (m_cnt == 45) begin m_phase = M_ARM; m_cnt = 0; end
                    else m_cnt++;
                end
                M_ARM: begin m_phase = M_RUN; m_elapsed = 0; end
                M_RUN: if (acc) m_abort();
                    else begin
                        m_elapsed++;
                        if (core_success) begin
                            m_phase = M_DONE; m_rv = 1; m_rf = 1; m_rn = core_nonce;
                        end else if (TO != 0 && m_elapsed == TO) begin
                            m_phase = M_DONE; m_rv = 1; m_rf = 0; m_rn = 0;
                        end
                    end
                default: if (acc) m_abort();
            endcase
        end
    endtask

    function automatic logic [255:0] job_sha();
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[255-8*i -: 8] = job[i];
        return r;
    endfunction

    function automatic logic [95:0] job_mh();
        logic [95:0] r;
        for (int i = 0; i < 12; i++) r[95-8*i -: 8] = job[32+i];
        return r;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("m_sha", sha_state, job_sha());
        chk("m_mh", {160'd0, message_head}, {160'd0, job_mh()});
        chk("m_tail", {difficulty, nonce_start_MSB}, {job[44], job[45]});
        chk("m_ctl", {in_ready, core_reset, busy},
            {m_phase != M_ARM, m_phase != M_RUN, m_phase == M_ARM || m_phase == M_RUN});
        chk("m_res", {result_valid, result_found, result_nonce}, {m_rv, m_rf, m_rn});
    endtask

    logic [367:0] spec_job = 368'hdc6a3b8d0c69421acb1a5434e536f7d5c3c1b9e44cbb9b8f95f0172efc48d2df_dc141787358b0553535f0119_03_00;
    logic [7:0]   jb [46];

    task automatic use_spec_job();
        for (int i = 0; i < 46; i++) jb[i] = spec_job[367-8*i -: 8];
    endtask

    task automatic use_random_job();
        for (int i = 0; i < 46; i++) jb[i] = 8'($urandom);
    endtask

    // Streams jb[first..45] back-to-back; optionally leaves in_valid high with next_byte afterwards.
    task automatic send_job(input int first, input bit keep_valid, input logic [7:0] next_byte);
        bit all_ready = 1;
        for (int i = first; i < 46; i++) begin
            in_valid = 1; in_data = jb[i];
            if (!in_ready) all_ready = 0;
            tick();
        end
        chk("load_ready", all_ready, 1);
        if (keep_valid) in_data = next_byte;
        else in_valid = 0;
    endtask

    task automatic chk_fields(input string name);
        logic [255:0] s;
        logic [95:0]  m;
        for (int i = 0; i < 32; i++) s[255-8*i -: 8] = jb[i];
        for (int i = 0; i < 12; i++) m[95-8*i -: 8] = jb[32+i];
        chk({name, "_sha"}, sha_state, s);
        chk({name, "_mh"}, {160'd0, message_head}, {160'd0, m});
        chk({name, "_tail"}, {difficulty, nonce_start_MSB}, {jb[44], jb[45]});
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          succ;
        logic [31:0] nonce;
        bit          e_ready, e_creset, e_busy, e_rv, e_rf;
        logic [31:0] e_rn;
    } vec_t;
    vec_t tbl [14];

    initial begin
        bit early;

        tbl[0] = '{0, 8'h00, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0};
        for (int i = 1; i <= 10; i++) tbl[i] = '{0, 8'h00, 0, 32'($urandom), 1, 0, 1, 0, 0, 32'h0};
        tbl[11] = '{0, 8'h00, 1, 32'h00001234, 1, 1, 0, 1, 1, 32'h00001234};
        tbl[12] = '{0, 8'h00, 0, 32'hdeadbeef, 1, 1, 0, 1, 1, 32'h00001234};
        tbl[13] = '{0, 8'h00, 1, 32'h55555555, 1, 1, 0, 1, 1, 32'h00001234};

        reset = 1; in_valid = 0; in_data = 0; core_success = 0; core_nonce = 0;
        tick();
        reset = 0;
        chk("rst_fields", sha_state, 256'd0);
        chk("rst_rest", {message_head, difficulty, nonce_start_MSB}, 112'd0);
        chk("rst_ctl", {core_reset, in_ready, busy}, 3'b110);
        chk("rst_res", {result_valid, result_found, result_nonce}, 34'd0);

        // Full load of the reference job, then the success-capture table.
        use_spec_job();
        send_job(0, 0, 8'h00);
        chk_fields("spec");
        chk("arm_ctl", {in_ready, core_reset, busy}, 3'b011);
        foreach (tbl[i]) begin
            in_valid = tbl[i].v; in_data = tbl[i].d;
            core_success = tbl[i].succ; core_nonce = tbl[i].nonce;
            tick();
            chk($sformatf("tbl%0d_ctl", i), {in_ready, core_reset, busy},
                {tbl[i].e_ready, tbl[i].e_creset, tbl[i].e_busy});
            chk($sformatf("tbl%0d_res", i), {result_valid, result_found, result_nonce},
                {tbl[i].e_rv, tbl[i].e_rf, tbl[i].e_rn});
        end
        core_success = 0;

        // Timeout lands exactly TO edges after RUN entry; a success on that edge wins.
        for (int pass = 0; pass < 2; pass++) begin
            use_random_job();
            send_job(0, 0, 8'h00);
            chk_fields("to");
            tick();
            early = 0;
            for (int k = 1; k < TO; k++) begin
                tick();
                if (result_valid) early = 1;
            end
            chk("to_early", early, 0);
            core_success = (pass == 1); core_nonce = 32'hcafef00d;
            tick();
            core_success = 0;
            chk("to_res", {result_valid, result_found, result_nonce, core_reset},
                (pass == 1) ? {1'b1, 1'b1, 32'hcafef00d, 1'b1} : {1'b1, 1'b0, 32'h0, 1'b1});
        end

        // Abort during RUN with 0xAA, then the remaining 45 bytes make a new job.
        use_random_job();
        send_job(0, 0, 8'h00);
        tick(); tick(); tick();
        in_valid = 1; in_data = 8'hAA;
        tick();
        in_valid = 0;
        chk("abort_ctl", {result_valid, core_reset, busy, in_ready}, 4'b0101);
        chk("abort_b0", sha_state[255:248], 8'hAA);
        jb[0] = 8'hAA;
        send_job(1, 0, 8'h00);
        chk_fields("abort");
        chk("abort_arm", {in_ready, busy}, 2'b01);

        // Abort coinciding with success: the result is discarded.
        tick();
        in_valid = 1; in_data = 8'h5C; core_success = 1; core_nonce = 32'h1;
        tick();
        in_valid = 0; core_success = 0;
        chk("abort_succ", {result_valid, result_found, core_reset, sha_state[255:248]}, {3'b001, 8'h5C});

        // Reset after 20 bytes discards the partial job and restarts the count.
        use_random_job();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1; in_data = jb[i]; tick();
        end
        in_valid = 0; reset = 1;
        tick();
        reset = 0;
        chk("mid_rst_sha", sha_state, 256'd0);
        chk("mid_rst_rest", {message_head, difficulty, nonce_start_MSB, core_reset, in_ready, busy},
            {112'd0, 3'b110});
        use_spec_job();
        send_job(0, 0, 8'h00);
        chk_fields("after_rst");

        // in_valid held across ARM: the ARM-cycle byte waits and lands as byte 0 of an abort.
        tick(); tick();
        use_random_job();
        send_job(0, 1, 8'h77);
        chk("bp_arm", {in_ready, core_reset}, 2'b01);
        tick();
        chk("bp_run", {core_reset, sha_state[255:248]}, {1'b0, jb[0]});
        tick();
        in_valid = 0;
        chk("bp_abort", {core_reset, result_valid, sha_state[255:248]}, {2'b10, 8'h77});

        // Random traffic against the model.
        for (int seg = 0; seg < 20; seg++) begin
            int pv;
            case ($urandom_range(2))
                0:       pv = 95;
                1:       pv = 50;
                default: pv = 1;
            endcase
            for (int c = 0; c < 300; c++) begin
                in_valid     = ($urandom_range(99) < pv);
                in_data      = 8'($urandom);
                core_success = ($urandom_range(79) == 0);
                core_nonce   = $urandom;
                reset        = ($urandom_range(499) == 0);
                tick();
                chk_model();
            end
        end
        reset = 0; in_valid = 0; core_success = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
